debug_display_ctrl: RTL and testbench
=====================================

Name: debug_display_ctrl

Overview:
Parametrised register-mapped driver for the board's debug seven-segment digits and LEDs. It replaces hard-wired segment/LED conduits with:
- per-digit hex decode, blank and blink masks;
- a scrolling message buffer;
- a test mode that lights every segment.

It sits behind a simple memory-mapped write/read port in the FPGA fabric. Its registered outputs drive the HEX and LEDR pins.

Parameters:
NUM_DIGITS, 6, number of seven-segment digits (1..8)
LED_WIDTH, 10, number of LED outputs (1..32)
MSG_DEPTH, 16, message buffer entries (power of 2, 2..64)
BLINK_DIV, 25000000, clk cycles per blink phase toggle (>=1)
SCROLL_DIV, 12500000, clk cycles per scroll step (>=1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe, one cycle per write
rd_en  in  1  read strobe
addr  in  3  register address
wr_data  in  32  write data
rd_data  out  32  read data, valid the cycle after rd_en
seg_out  out  7*NUM_DIGITS  active-low segments {g,f,e,d,c,b,a} per digit; digit 0 in the MS slice [7*NUM_DIGITS-1 -: 7]
led_out  out  LED_WIDTH  LED drive, active-high
msg_full  out  1  message buffer count == MSG_DEPTH
overflow  out  1  sticky: a push was dropped

Behaviour:
- Reset (async assert, sync release to clk):
  - all registers, counters and buffer pointers = 0;
  - seg_out all ones (blank); led_out = 0; rd_data = 0; msg_full = 0; overflow = 0.
- Register map, all writes take effect at the write edge:
  - 0 CTRL: [0] scroll_en, [1] test_mode.
  - 1 VALUE: digit i uses nibble [4i+3:4i].
  - 2 BLANK: [NUM_DIGITS-1:0], 1 = digit blank.
  - 3 BLINK: [NUM_DIGITS-1:0], 1 = digit blinks.
  - 4 LEDS: [LED_WIDTH-1:0].
  - 5 MSG_PUSH: appends entry wr_data[4:0] to the buffer; bit4 = blank entry, [3:0] = hex.
  - 6 MSG_CLEAR: any write sets count, window start, overflow and the scroll counter to 0.
  - 7: reserved; writes ignored, reads 0.
- Reads:
  - rd_data is registered, one-cycle latency.
  - Addresses 0–4 return the register, zero-extended.
  - Address 5 returns {overflow at bit 31, count in [7:0]}.
  - Addresses 6 and 7 return 0.
  - Without rd_en, rd_data holds its value.
- Hex decode, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Blink:
  - A free-running counter counts 0..BLINK_DIV-1; phase toggles at wrap.
  - While phase=1, digits with a BLINK bit set are blank.
- Scroll, active when scroll_en=1:
  - A counter counts 0..SCROLL_DIV-1; at wrap, start advances to (start+1) mod count when count>0.
  - Digit i shows entry[(start+i) mod count] for i<count; otherwise it is blank.
  - count=0 gives all digits blank; a blank entry gives a blank digit.
  - VALUE is ignored while scrolling. BLANK and BLINK still apply.
  - Clearing scroll_en freezes start; start is reset only by MSG_CLEAR.
- Display priority per digit, highest first:
  1. test_mode: segment pattern 0000000.
  2. BLANK bit set.
  3. Blink phase blanks the digit.
  4. Scroll entry or VALUE nibble.
- Output timing: seg_out and led_out are registered. A register write at edge T is visible on the outputs at edge T+1.
- Buffer is a circular store with write pointer = count:
  - A push when count==MSG_DEPTH is dropped and sets overflow.
  - A push and a clear in the same cycle: clear wins and the push is discarded.
  - A scroll step in the same cycle as a push uses the pre-push count.
  - count is MSG_DEPTH+1 states wide.
- Reset assertion mid-operation immediately returns every output to its reset value, regardless of scroll or blink state.

Test Plan:
1. Reset, then write VALUE=0x00543210 with NUM_DIGITS=6 → two cycles after the write, digit0..5 show 1000000, 1111001, 0100100, 0110000, 0011001, 0010010; led_out=0 before any LEDS write.
2. BLINK_DIV=4, BLINK=0b000001, VALUE=0x8 → digit0 alternates 0000000 / 1111111 every 4 cycles; other digits stay steady at 1000000.
3. SCROLL_DIV=3, push 0xA, 0xB, 0xC, set scroll_en → digit0 steps A,b,C,A every 3 cycles; digit1 shows b,C,A; digits 3..5 blank.
4. MSG_DEPTH=4: push 5 entries → msg_full=1 after the 4th push; 5th push is dropped, overflow=1, STATUS read = 0x80000004. Then MSG_CLEAR → STATUS=0, msg_full=0.
5. Same-cycle push and clear with count=2 → count=0 and overflow=0 afterwards; test_mode=1 with BLANK=0x3F → all digits 0000000.
6. Mid-scroll reset_n low asynchronously (between edges) → seg_out is all ones and led_out=0 without waiting for a clock edge; after release, a read of address 5 returns 0.

Source files
------------

// File: rtl/debug_display_ctrl.sv
// Register-mapped driver for the debug seven-segment digits and LEDs, with hex decode, blank/blink masks, message scroll and test mode.
// Latency: a write is visible on seg_out/led_out one clock after the write edge; rd_data is valid the cycle after rd_en.
// Backpressure: none; writes and reads always complete, and a push to a full message buffer is dropped and flagged in overflow.
module debug_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int LED_WIDTH  = 10,
  parameter int MSG_DEPTH  = 16,
  parameter int BLINK_DIV  = 25000000,
  parameter int SCROLL_DIV = 12500000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic [2:0]              addr,
  input  logic [31:0]             wr_data,
  output logic [31:0]             rd_data,
  output logic [7*NUM_DIGITS-1:0] seg_out,
  output logic [LED_WIDTH-1:0]    led_out,
  output logic                    msg_full,
  output logic                    overflow
);

  // Buffer index, count (0..MSG_DEPTH inclusive) and wide sum for modulo wrap.
  localparam int AW = $clog2(MSG_DEPTH);
  localparam int CW = $clog2(MSG_DEPTH + 1);
  localparam int SW = CW + 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int KW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  localparam logic [CW-1:0] DEPTH_C     = CW'(MSG_DEPTH);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_DIV - 1);
  localparam logic [KW-1:0] SCROLL_LAST = KW'(SCROLL_DIV - 1);

  localparam logic [2:0] A_CTRL  = 3'd0;
  localparam logic [2:0] A_VALUE = 3'd1;
  localparam logic [2:0] A_BLANK = 3'd2;
  localparam logic [2:0] A_BLINK = 3'd3;
  localparam logic [2:0] A_LEDS  = 3'd4;
  localparam logic [2:0] A_PUSH  = 3'd5;
  localparam logic [2:0] A_CLEAR = 3'd6;

  logic                  scroll_en;
  logic                  test_mode;
  logic [31:0]           value_r;
  logic [NUM_DIGITS-1:0] blank_r;
  logic [NUM_DIGITS-1:0] blink_r;
  logic [LED_WIDTH-1:0]  leds_r;

  logic [4:0]            mem [MSG_DEPTH];
  logic [CW-1:0]         count;
  logic [AW-1:0]         start;
  logic [BW-1:0]         blink_cnt;
  logic                  blink_phase;
  logic [KW-1:0]         scroll_cnt;
  logic [SW-1:0]         start_inc;

  logic [7*NUM_DIGITS-1:0] seg_nxt;

  logic do_clear;
  logic do_push;

  assign do_clear  = wr_en && (addr == A_CLEAR);
  assign do_push   = wr_en && (addr == A_PUSH);
  assign msg_full  = (count == DEPTH_C);
  assign start_inc = SW'(start) + SW'(1);

  // Active-low gfedcba pattern for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] p;
    case (h)
      4'h0: p = 7'b1000000;
      4'h1: p = 7'b1111001;
      4'h2: p = 7'b0100100;
      4'h3: p = 7'b0110000;
      4'h4: p = 7'b0011001;
      4'h5: p = 7'b0010010;
      4'h6: p = 7'b0000010;
      4'h7: p = 7'b1111000;
      4'h8: p = 7'b0000000;
      4'h9: p = 7'b0010000;
      4'hA: p = 7'b0001000;
      4'hB: p = 7'b0000011;
      4'hC: p = 7'b1000110;
      4'hD: p = 7'b0100001;
      4'hE: p = 7'b0000110;
      default: p = 7'b0001110;
    endcase
    return p;
  endfunction

  // Control/data registers written straight from the bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scroll_en <= 1'b0;
      test_mode <= 1'b0;
      value_r   <= '0;
      blank_r   <= '0;
      blink_r   <= '0;
      leds_r    <= '0;
    end else if (wr_en) begin
      case (addr)
        A_CTRL:  begin scroll_en <= wr_data[0]; test_mode <= wr_data[1]; end
        A_VALUE: value_r <= wr_data;
        A_BLANK: blank_r <= wr_data[NUM_DIGITS-1:0];
        A_BLINK: blink_r <= wr_data[NUM_DIGITS-1:0];
        A_LEDS:  leds_r  <= wr_data[LED_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // Message store: write pointer is the count; a clear outranks any push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < MSG_DEPTH; i++) mem[i] <= '0;
    end else if (do_clear) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (do_push) begin
      if (count == DEPTH_C) begin
        overflow <= 1'b1;
      end else begin
        mem[AW'(count)] <= wr_data[4:0];
        count           <= count + CW'(1);
      end
    end
  end

  // Scroll timer and window start; the step sees the count from before any same-cycle push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scroll_cnt <= '0;
      start      <= '0;
    end else if (do_clear) begin
      scroll_cnt <= '0;
      start      <= '0;
    end else if (scroll_en) begin
      if (scroll_cnt == SCROLL_LAST) begin
        scroll_cnt <= '0;
        if (count != '0) start <= (start_inc >= SW'(count)) ? '0 : start + AW'(1);
      end else begin
        scroll_cnt <= scroll_cnt + KW'(1);
      end
    end
  end

  // Free-running blink timer; the phase flips each time it wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // Per-digit segment selection: test mode, then blank, then blink, then scroll entry or VALUE nibble.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    logic [SW-1:0] sum;
    logic [AW-1:0] idx;
    logic [4:0]    entry;
    logic          in_msg;
    logic [6:0]    pat;

    // Pick the pattern for digit g; digit 0 lands in the most significant slice.
    always_comb begin
      sum = SW'(start) + SW'(g);
      if (sum >= SW'(count)) sum = sum - SW'(count);
      idx    = AW'(sum);
      entry  = mem[idx];
      in_msg = (SW'(g) < SW'(count));
      if (test_mode)                                pat = 7'b0000000;
      else if (blank_r[g] || (blink_r[g] && blink_phase)) pat = 7'b1111111;
      else if (scroll_en)                           pat = (in_msg && !entry[4]) ? hex7(entry[3:0]) : 7'b1111111;
      else                                          pat = hex7(value_r[4*g +: 4]);
    end

    assign seg_nxt[7*(NUM_DIGITS-1-g) +: 7] = pat;
  end

  // Registered pin drive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_out <= '1;
      led_out <= '0;
    end else begin
      seg_out <= seg_nxt;
      led_out <= leds_r;
    end
  end

  // Registered read port; holds its value when rd_en is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      case (addr)
        A_CTRL:  rd_data <= {30'b0, test_mode, scroll_en};
        A_VALUE: rd_data <= value_r;
        A_BLANK: rd_data <= 32'(blank_r);
        A_BLINK: rd_data <= 32'(blink_r);
        A_LEDS:  rd_data <= 32'(leds_r);
        A_PUSH:  rd_data <= {overflow, 23'b0, 8'(count)};
        default: rd_data <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_display_ctrl.sv
// Bench for debug_display_ctrl: table-driven display vectors, read scoreboard, blink/scroll/buffer/reset sequences.
// Latency: checks seg_out/led_out one clock after the write edge and rd_data one clock after rd_en.
// Backpressure: not applicable; stimulus is driven on the falling edge and sampled on the falling edge.
module tb_debug_display_ctrl;

  localparam int ND = 6;

  localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100, P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001, P5 = 7'b0010010, P6 = 7'b0000010, P7 = 7'b1111000;
  localparam logic [6:0] P8 = 7'b0000000, P9 = 7'b0010000, PA = 7'b0001000, PB = 7'b0000011;
  localparam logic [6:0] PC = 7'b1000110, PD = 7'b0100001, PE = 7'b0000110, PF = 7'b0001110;
  localparam logic [6:0] PX = 7'b1111111;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [2:0]    addr = '0;
  logic [31:0]   wr_data = '0;
  logic [31:0]   rd_data;
  logic [7*ND-1:0] seg_out;
  logic [9:0]    led_out;
  logic          msg_full;
  logic          overflow;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] exp_q[$];
  string       nm_q[$];
  logic        rd_seen = 1'b0;

  debug_display_ctrl #(
    .NUM_DIGITS(ND), .LED_WIDTH(10), .MSG_DEPTH(4), .BLINK_DIV(4), .SCROLL_DIV(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .seg_out(seg_out), .led_out(led_out),
    .msg_full(msg_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1; addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [2:0] a, input logic [31:0] e);
    @(negedge clk);
    rd_en = 1'b1; addr = a;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  // Read scoreboard: a response is due the cycle after each rd_en.
  always @(posedge clk) rd_seen <= rd_en;
  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) chk("rd_unexpected", 64'(rd_data), 64'hDEAD);
      else chk(nm_q.pop_front(), 64'(rd_data), 64'(exp_q.pop_front()));
    end
  end

  typedef struct {
    logic [31:0]   value;
    logic [5:0]    blank;
    logic          test;
    logic [7*ND-1:0] exp;
  } vec_t;

  vec_t vecs[4];
  logic [6:0] s[24];
  logic [6:0] ent[3];

  function automatic logic [7*ND-1:0] scroll_exp(input int st);
    return {ent[st % 3], ent[(st + 1) % 3], ent[(st + 2) % 3], {3{PX}}};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int k;
    bool_placeholder: begin end
    vecs[0] = '{32'h0054_3210, 6'b000000, 1'b0, {P0, P1, P2, P3, P4, P5}};
    vecs[1] = '{32'h00FE_DCBA, 6'b000000, 1'b0, {PA, PB, PC, PD, PE, PF}};
    vecs[2] = '{32'h0098_7654, 6'b100101, 1'b0, {PX, P5, PX, P7, P8, PX}};
    vecs[3] = '{32'h0012_3456, 6'b111111, 1'b1, {6{P8}}};
    ent[0] = PA; ent[1] = PB; ent[2] = PC;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("reset_seg", 64'(seg_out), 64'({7*ND{1'b1}}));
    chk("reset_led", 64'(led_out), 64'h0);
    chk("reset_rd_data", 64'(rd_data), 64'h0);
    chk("reset_msg_full", 64'(msg_full), 64'h0);
    chk("reset_overflow", 64'(overflow), 64'h0);
    reset_n = 1'b1;

    // Display vectors.
    for (int v = 0; v < 4; v++) begin
      wr(3'd0, vecs[v].test ? 32'h2 : 32'h0);
      wr(3'd1, vecs[v].value);
      wr(3'd2, 32'(vecs[v].blank));
      @(negedge clk);
      chk($sformatf("vec%0d_seg", v), 64'(seg_out), 64'(vecs[v].exp));
      rd($sformatf("vec%0d_rd_value", v), 3'd1, vecs[v].value);
      rd($sformatf("vec%0d_rd_blank", v), 3'd2, 32'(vecs[v].blank));
      rd($sformatf("vec%0d_rd_ctrl", v), 3'd0, vecs[v].test ? 32'h2 : 32'h0);
    end

    // LED timing: still old on the write edge, new one edge later; upper bits truncated.
    chk("led_before_write", 64'(led_out), 64'h0);
    wr(3'd4, 32'hFFFF_F155);
    chk("led_same_edge", 64'(led_out), 64'h0);
    @(negedge clk);
    chk("led_after", 64'(led_out), 64'h155);
    rd("rd_leds", 3'd4, 32'h155);
    wr(3'd7, 32'hFFFF_FFFF);
    rd("rd_reserved", 3'd7, 32'h0);
    rd("rd_clear_addr", 3'd6, 32'h0);

    // Blink: digit0 alternates 8/blank in runs of 4 cycles; other digits steady.
    wr(3'd0, 32'h0);
    wr(3'd2, 32'h0);
    wr(3'd1, 32'h8);
    wr(3'd3, 32'h1);
    @(negedge clk);
    k = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      s[j] = seg_out[7*ND-1 -: 7];
      if (seg_out[7*ND-8:0] !== {5{P0}}) k = k + 1;
    end
    chk("blink_others_steady", 64'(k), 64'h0);
    k = 0;
    for (int j = 4; j >= 1; j--) if (s[j] !== s[j-1]) k = j;
    chk("blink_toggle_seen", 64'(k != 0), 64'h1);
    if (k == 0) k = 1;
    chk("blink_levels", 64'((s[k] === P8) || (s[k] === PX)), 64'h1);
    for (int j = k; j < k + 12; j++)
      chk($sformatf("blink_s%0d", j - k), 64'(s[j]),
          64'((((j - k) / 4) % 2 == 0) ? s[k] : ((s[k] === PX) ? P8 : PX)));
    wr(3'd3, 32'h0);

    // Scroll three entries: window steps every 3 cycles, digits 3..5 blank.
    wr(3'd6, 32'h0);
    wr(3'd5, 32'h0A);
    wr(3'd5, 32'h0B);
    wr(3'd5, 32'h1C & 32'h0F);
    wr(3'd0, 32'h1);
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      s[j] = 7'h0;
      chk($sformatf("scroll_s%0d_raw", j), 64'(seg_out[20:0]), 64'({3{PX}}));
      if (seg_out[41:21] === {PA, PB, PC}) s[j] = 7'd0;
      else if (seg_out[41:21] === {PB, PC, PA}) s[j] = 7'd1;
      else if (seg_out[41:21] === {PC, PA, PB}) s[j] = 7'd2;
      else s[j] = 7'd9;
    end
    chk("scroll_first", 64'(s[0]), 64'h0);
    k = 0;
    for (int j = 3; j >= 1; j--) if (s[j] !== s[0]) k = j;
    chk("scroll_step_seen", 64'(k != 0), 64'h1);
    if (k == 0) k = 1;
    for (int j = k; j < k + 9; j++)
      chk($sformatf("scroll_step_%0d", j - k), 64'(s[j]), 64'((1 + (j - k) / 3) % 3));
    wr(3'd0, 32'h0);
    @(negedge clk);
    chk("scroll_off_value", 64'(seg_out), 64'({P8, {5{P0}}}));

    // Buffer fill, overflow and clear.
    wr(3'd6, 32'h0);
    for (int j = 0; j < 3; j++) wr(3'd5, 32'(j));
    chk("full_after3", 64'(msg_full), 64'h0);
    wr(3'd5, 32'h3);
    chk("full_after4", 64'(msg_full), 64'h1);
    chk("ovf_after4", 64'(overflow), 64'h0);
    wr(3'd5, 32'h4);
    chk("ovf_after5", 64'(overflow), 64'h1);
    rd("status_overflow", 3'd5, 32'h8000_0004);
    wr(3'd6, 32'h0);
    chk("full_after_clear", 64'(msg_full), 64'h0);
    chk("ovf_after_clear", 64'(overflow), 64'h0);
    rd("status_cleared", 3'd5, 32'h0);

    // Push immediately followed by clear from count=2.
    wr(3'd5, 32'h1);
    wr(3'd5, 32'h2);
    rd("status_two", 3'd5, 32'h2);
    @(negedge clk);
    wr_en = 1'b1; addr = 3'd5; wr_data = 32'h3;
    @(negedge clk);
    addr = 3'd6;
    @(negedge clk);
    wr_en = 1'b0;
    rd("status_push_clear", 3'd5, 32'h0);

    // Asynchronous reset mid-scroll.
    wr(3'd4, 32'h2AA);
    wr(3'd5, 32'h1);
    wr(3'd5, 32'h2);
    wr(3'd0, 32'h1);
    rd("rd_leds_pre_reset", 3'd4, 32'h2AA);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_seg", 64'(seg_out), 64'({7*ND{1'b1}}));
    chk("arst_led", 64'(led_out), 64'h0);
    chk("arst_rd_data", 64'(rd_data), 64'h0);
    chk("arst_msg_full", 64'(msg_full), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rd("status_after_reset", 3'd5, 32'h0);
    rd("ctrl_after_reset", 3'd0, 32'h0);

    repeat (3) @(negedge clk);
    chk("rd_queue_drained", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
